// File: rtl/z80_io_responder.sv
// Z80 I/O target: answers IN/OUT cycles to a small register window, inserts
// programmable wait states, and supplies an interrupt vector on acknowledge.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no cycle in progress, watching for a window hit or intack
// S_WAIT   | holding nWAIT low while the wait-state counter runs down
// S_ACCESS | register write or read-data launch happens on this edge
// S_DONE   | read data held on the bus until nIORQ is released
// S_ACK    | interrupt vector driven until nIORQ is released
module z80_io_responder #(
    parameter logic [7:0] PORT_BASE   = 8'h10,
    parameter int         NUM_REGS    = 4,
    parameter int         WAIT_STATES = 2,
    parameter logic [7:0] VECTOR      = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic [7:0]            A,
    input  logic [7:0]            D_in,
    output logic [7:0]            D_out,
    output logic                  D_oe,
    input  logic                  nIORQ,
    input  logic                  nRD,
    input  logic                  nWR,
    input  logic                  nM1,
    output logic                  nWAIT,
    output logic                  nINT,
    input  logic                  irq_req,
    output logic [NUM_REGS*8-1:0] regs_out
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               nwait_q, nwait_d;
    logic               doe_q, doe_d;
    logic [7:0]         dout_q, dout_d;
    logic               pend_q, pend_d;
    logic               ie_q, ie_d;
    logic               nint_q, nint_d;
    // Slot 0 is the CTRL register (ie/pending), so data storage starts at 1.
    logic [7:0]         regs_q [1:NUM_REGS-1];
    logic [7:0]         regs_d [1:NUM_REGS-1];

    logic io_rd, io_wr, intack, match, pend_clr, strobe_held;

    // Bus decode, next-state and next-output computation.
    always_comb begin
        io_rd       = ~nIORQ & ~nRD & nM1;
        io_wr       = ~nIORQ & ~nWR & nM1;
        intack      = ~nIORQ & ~nM1;
        match       = (A[7:IDX_W] == PORT_BASE[7:IDX_W]);
        strobe_held = wr_q ? io_wr : io_rd;

        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        nwait_d  = nwait_q;
        doe_d    = doe_q;
        dout_d   = dout_q;
        ie_d     = ie_q;
        regs_d   = regs_q;
        pend_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((io_rd | io_wr) & match) begin
                    idx_d = A[IDX_W-1:0];
                    wr_d  = io_wr;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                        nwait_d = 1'b0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end else if (intack & pend_q & ie_q) begin
                    state_d = S_ACK;
                    doe_d   = 1'b1;
                    dout_d  = VECTOR;
                end
            end
            S_WAIT: begin
                // A withdrawn strobe aborts the cycle with no side effects.
                if (!strobe_held) begin
                    nwait_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    nwait_d = 1'b1;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    if (idx_q == '0) begin
                        ie_d     = D_in[1];
                        pend_clr = D_in[0];
                    end else begin
                        regs_d[idx_q] = D_in;
                    end
                end else begin
                    doe_d  = 1'b1;
                    dout_d = (idx_q == '0) ? {6'b0, ie_q, pend_q} : regs_q[idx_q];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (nIORQ) begin
                    doe_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (nIORQ) begin
                    pend_clr = 1'b1;
                    doe_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new request wins over any clear arriving on the same edge.
        pend_d = irq_req | (pend_q & ~pend_clr);
        nint_d = ~(pend_d & ie_d);
    end

    // State and registered outputs, all cleared asynchronously.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= 4'd0;
            nwait_q <= 1'b1;
            doe_q   <= 1'b0;
            dout_q  <= 8'h00;
            pend_q  <= 1'b0;
            ie_q    <= 1'b0;
            nint_q  <= 1'b1;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            nwait_q <= nwait_d;
            doe_q   <= doe_d;
            dout_q  <= dout_d;
            pend_q  <= pend_d;
            ie_q    <= ie_d;
            nint_q  <= nint_d;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flatten register contents; the CTRL slot is shown as zeros.
    always_comb begin
        regs_out = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_out[i*8 +: 8] = regs_q[i];
        end
    end

    assign D_out = dout_q;
    assign D_oe  = doe_q;
    assign nWAIT = nwait_q;
    assign nINT  = nint_q;

endmodule

// File: tb/tb_z80_io_responder.sv
// Bench for z80_io_responder: directed table, hand-written corner sequences
// and randomized bus traffic checked against a register/flag model.
module tb_z80_io_responder;

    localparam int         WS   = 2;
    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] VEC  = 8'hFF;

    logic        CLK, nRESET;
    logic [7:0]  A, D_in, D_out, D_out0;
    logic        D_oe, D_oe0, nIORQ, nRD, nWR, nM1, nWAIT, nWAIT0, nINT, nINT0, irq_req;
    logic [31:0] regs_out, regs_out0;
    logic        en0;
    logic        niorq0, nrd0, nwr0, irq0;

    assign niorq0 = en0 ? nIORQ : 1'b1;
    assign nrd0   = en0 ? nRD : 1'b1;
    assign nwr0   = en0 ? nWR : 1'b1;
    assign irq0   = en0 & irq_req;

    z80_io_responder #(.PORT_BASE(BASE), .NUM_REGS(4), .WAIT_STATES(WS), .VECTOR(VEC)) dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nWAIT(nWAIT), .nINT(nINT),
        .irq_req(irq_req), .regs_out(regs_out));

    z80_io_responder #(.PORT_BASE(BASE), .NUM_REGS(4), .WAIT_STATES(0), .VECTOR(VEC)) dut0 (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(D_out0), .D_oe(D_oe0),
        .nIORQ(niorq0), .nRD(nrd0), .nWR(nwr0), .nM1(nM1), .nWAIT(nWAIT0), .nINT(nINT0),
        .irq_req(irq0), .regs_out(regs_out0));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_pass = 0;
    int n_total = 0;
    int bad0 = 0;

    // The zero-wait build must never pull nWAIT low.
    always @(negedge CLK) begin
        if (nRESET && !nWAIT0) bad0++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Model: register contents, interrupt enable and pending flag.
    logic [7:0] m_regs [4];
    bit         m_ie, m_pend;

    function automatic logic [31:0] m_flat();
        return {m_regs[3], m_regs[2], m_regs[1], 8'h00};
    endfunction

    function automatic bit in_window(input logic [7:0] port);
        return port[7:2] == BASE[7:2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ie = 0;
        m_pend = 0;
    endtask

    task automatic model_apply(input bit wr, input bit mem, input logic [7:0] port,
                               input logic [7:0] data, input bit irq);
        if (wr && !mem && in_window(port)) begin
            if (port[1:0] == 2'd0) begin
                m_ie = data[1];
                if (data[0]) m_pend = 0;
            end else begin
                m_regs[port[1:0]] = data;
            end
        end
        if (irq) m_pend = 1;
    endtask

    int         r_wait, r_oe_k, r_oe0_k;
    logic [7:0] r_rdat, r_rdat0;
    logic       r_oe_last, r_oe_rel, r_nwait_rel;

    task automatic io_cycle(input bit wr, input bit mem, input logic [7:0] port,
                            input logic [7:0] data, input int hold, input int irq_k);
        r_wait = 0; r_oe_k = -1; r_oe0_k = -1; r_rdat = 0; r_rdat0 = 0; r_oe_last = 0;
        @(negedge CLK);
        A = port; D_in = data; nM1 = 1'b1; nIORQ = mem; nRD = wr; nWR = !wr;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            if (!nWAIT) r_wait++;
            if (D_oe && r_oe_k < 0) begin r_oe_k = k; r_rdat = D_out; end
            if (D_oe0 && r_oe0_k < 0) begin r_oe0_k = k; r_rdat0 = D_out0; end
            r_oe_last = D_oe;
            irq_req = (k == irq_k);
        end
        nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; irq_req = 1'b0;
        @(negedge CLK);
        r_oe_rel = D_oe;
        r_nwait_rel = nWAIT;
    endtask

    // Full bus cycle with expectations derived from the model.
    task automatic run_io(input bit wr, input bit mem, input logic [7:0] port,
                          input logic [7:0] data, input int irq_k, input string tag);
        bit         hit = !mem && in_window(port);
        logic [7:0] exp_rd = (port[1:0] == 2'd0) ? {6'b0, m_ie, m_pend} : m_regs[port[1:0]];
        io_cycle(wr, mem, port, data, 5, irq_k);
        check({tag, "_wait"}, r_wait, hit ? WS : 0);
        check({tag, "_oe_lat"}, r_oe_k, (hit && !wr) ? WS + 1 : -1);
        if (hit && !wr) begin
            check({tag, "_rdata"}, r_rdat, exp_rd);
            check({tag, "_oe_hold"}, r_oe_last, 1);
            check({tag, "_oe_rel"}, r_oe_rel, 0);
        end
        check({tag, "_nwait_rel"}, r_nwait_rel, 1);
        model_apply(wr, mem, port, data, irq_k >= 0);
        check({tag, "_regs"}, regs_out, m_flat());
        check({tag, "_nint"}, nINT, !(m_pend && m_ie));
    endtask

    task automatic irq_pulse(input string tag);
        @(negedge CLK);
        irq_req = 1'b1;
        @(negedge CLK);
        irq_req = 1'b0;
        m_pend = 1;
        check({tag, "_nint"}, nINT, !(m_pend && m_ie));
    endtask

    task automatic intack_cycle(input string tag);
        bit         resp = m_pend && m_ie;
        int         oe_n = 0, wait_n = 0;
        logic [7:0] vec_seen = 8'h00;
        @(negedge CLK);
        nM1 = 1'b0; nIORQ = 1'b0; A = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (D_oe) begin
                oe_n++;
                if (k == 0) vec_seen = D_out;
            end
            if (!nWAIT) wait_n++;
        end
        nM1 = 1'b1; nIORQ = 1'b1;
        @(negedge CLK);
        check({tag, "_ack_oe_cycles"}, oe_n, resp ? 3 : 0);
        if (resp) check({tag, "_ack_vector"}, vec_seen, VEC);
        check({tag, "_ack_wait"}, wait_n, 0);
        check({tag, "_ack_oe_rel"}, D_oe, 0);
        if (resp) m_pend = 0;
        check({tag, "_ack_nint"}, nINT, !(m_pend && m_ie));
    endtask

    typedef struct {
        bit         wr;
        bit         mem;
        logic [7:0] port;
        logic [7:0] data;
        int         exp_wait;
        int         exp_oe;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1, 0, 8'h11, 8'h5A, 2, -1, 8'h00};
        tbl[1] = '{0, 0, 8'h11, 8'h00, 2,  3, 8'h5A};
        tbl[2] = '{1, 0, 8'h13, 8'hC3, 2, -1, 8'h00};
        tbl[3] = '{0, 0, 8'h13, 8'h00, 2,  3, 8'hC3};
        tbl[4] = '{1, 0, 8'h20, 8'h77, 0, -1, 8'h00};
        tbl[5] = '{0, 0, 8'h20, 8'h00, 0, -1, 8'h00};
        tbl[6] = '{0, 0, 8'h10, 8'h00, 2,  3, 8'h00};
        tbl[7] = '{0, 0, 8'h12, 8'h00, 2,  3, 8'h00};
        tbl[8] = '{1, 0, 8'h90, 8'h11, 0, -1, 8'h00};
        tbl[9] = '{0, 1, 8'h11, 8'h00, 0, -1, 8'h00};

        nRESET = 1'b1; en0 = 1'b0;
        A = 8'h00; D_in = 8'h00; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; irq_req = 1'b0;
        model_reset();

        #3 nRESET = 1'b0;
        #1;
        check("rst_doe", D_oe, 0);
        check("rst_dout", D_out, 0);
        check("rst_nwait", nWAIT, 1);
        check("rst_nint", nINT, 1);
        check("rst_regs", regs_out, 0);
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            io_cycle(tbl[i].wr, tbl[i].mem, tbl[i].port, tbl[i].data, 5, -1);
            check($sformatf("tbl%0d_wait", i), r_wait, tbl[i].exp_wait);
            check($sformatf("tbl%0d_oe_lat", i), r_oe_k, tbl[i].exp_oe);
            if (tbl[i].exp_oe >= 0) begin
                check($sformatf("tbl%0d_rdata", i), r_rdat, tbl[i].exp_rd);
                check($sformatf("tbl%0d_oe_rel", i), r_oe_rel, 0);
            end
            model_apply(tbl[i].wr, tbl[i].mem, tbl[i].port, tbl[i].data, 0);
            check($sformatf("tbl%0d_regs", i), regs_out, m_flat());
        end
        check("tbl_regs_final", regs_out, 32'hC3005A00);

        // Interrupt enable, request and acknowledge.
        run_io(1, 0, 8'h10, 8'h02, -1, "ctrl_ie");
        check("ie_nint_idle", nINT, 1);
        irq_pulse("irq1");
        check("irq1_nint_low", nINT, 0);
        intack_cycle("ack1");
        check("ack1_nint_high", nINT, 1);
        run_io(0, 0, 8'h10, 8'h00, -1, "ctrl_rd");

        // Request arriving on the same edge as a clearing CTRL write.
        irq_pulse("irq2");
        run_io(1, 0, 8'h10, 8'h03, 2, "ctrl_race");
        check("race_nint_low", nINT, 0);
        run_io(0, 0, 8'h20, 8'h00, -1, "oow_pending");
        run_io(1, 0, 8'h10, 8'h01, -1, "ctrl_clr");

        // Strobe withdrawn during wait states: no write, back to idle.
        io_cycle(1, 0, 8'h12, 8'hAA, 1, -1);
        check("abort_wait", r_wait, 1);
        check("abort_nwait_rel", r_nwait_rel, 1);
        check("abort_regs", regs_out, m_flat());
        run_io(0, 0, 8'h12, 8'h00, -1, "abort_rd");

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            int         op = $urandom_range(0, 4);
            logic [7:0] p = 8'($urandom_range(0, 255));
            logic [7:0] d = 8'($urandom);
            case (op)
                0: run_io(1, 0, BASE | {6'b0, p[1:0]}, d, -1, $sformatf("rnd%0d_wr", n));
                1: run_io(0, 0, BASE | {6'b0, p[1:0]}, d, -1, $sformatf("rnd%0d_rd", n));
                2: begin
                    if (in_window(p)) p[7] = ~p[7];
                    run_io(p[0], p[1], p[1] ? (BASE | {6'b0, p[3:2]}) : p, d, -1,
                           $sformatf("rnd%0d_miss", n));
                end
                3: irq_pulse($sformatf("rnd%0d_irq", n));
                default: intack_cycle($sformatf("rnd%0d", n));
            endcase
        end

        // Zero-wait-state build: one-edge read latency.
        en0 = 1'b1;
        run_io(1, 0, 8'h13, 8'h3C, -1, "ws0_wr");
        check("ws0_wr_oe", r_oe0_k, -1);
        run_io(0, 0, 8'h13, 8'h00, -1, "ws0_rd");
        check("ws0_rd_lat", r_oe0_k, 1);
        check("ws0_rd_data", r_rdat0, 8'h3C);
        check("ws0_regs", regs_out0, 32'h3C000000);
        check("ws0_nint", nINT0, 1);
        en0 = 1'b0;

        // Asynchronous reset while read data is on the bus.
        run_io(1, 0, 8'h11, 8'h96, -1, "prerst_wr");
        run_io(1, 0, 8'h10, 8'h02, -1, "prerst_ie");
        irq_pulse("prerst_irq");
        @(negedge CLK);
        A = 8'h11; nM1 = 1'b1; nIORQ = 1'b0; nRD = 1'b0;
        repeat (5) @(negedge CLK);
        check("prerst_doe", D_oe, 1);
        check("prerst_nint", nINT, 0);
        #2 nRESET = 1'b0;
        #1;
        check("arst_doe", D_oe, 0);
        check("arst_nwait", nWAIT, 1);
        check("arst_nint", nINT, 1);
        check("arst_regs", regs_out, 0);
        nIORQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        nRESET = 1'b1;
        model_reset();
        run_io(0, 0, 8'h11, 8'h00, -1, "postrst_rd");

        check("ws0_nwait_low_cycles", bad0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
